// File: rtl/alu_result_queue.sv
// In-order result buffer between the ALU and register-file write-back.
// Drops illegal-opcode results, and latches a sticky flag when a captured zero flag disagrees with its data.
module alu_result_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [DATA_WIDTH-1:0]   IN_DATA,
    input  logic                    IN_ZERO,
    input  logic [OPRN_WIDTH-1:0]   IN_OPRN,
    input  logic [ADDR_WIDTH-1:0]   IN_DST,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DATA_WIDTH-1:0]   OUT_DATA,
    output logic                    OUT_ZERO,
    output logic [ADDR_WIDTH-1:0]   OUT_DST,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic [7:0]              DISCARD_CNT,
    output logic                    ZERO_ERR
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL     = CNT_W'(DEPTH);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MIN = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MAX = OPRN_WIDTH'(9);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_zero [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_dst  [DEPTH];

    logic [PTR_W-1:0] head, tail, head_next;
    logic [CNT_W-1:0] count, count_next;
    logic             legal, accept, push, discard, pop, bypass;

    assign IN_READY  = (count != FULL);
    assign OUT_VALID = (count != '0);
    assign COUNT     = count;

    assign legal     = (IN_OPRN >= OPRN_MIN) && (IN_OPRN <= OPRN_MAX);
    assign accept    = IN_VALID && IN_READY;
    assign push      = accept && legal;
    assign discard   = accept && !legal;
    assign pop       = OUT_VALID && OUT_READY;
    assign head_next = head + PTR_W'(pop);

    // The entry being written this edge becomes the new head when nothing older survives.
    assign bypass    = push && (count == CNT_W'(pop));

    // NOTE: always_comb assigns every output a default first so no latch can be inferred.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; COUNT alone decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[tail] <= IN_DATA;
            mem_zero[tail] <= IN_ZERO;
            mem_dst[tail]  <= IN_DST;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            DISCARD_CNT <= '0;
            ZERO_ERR    <= 1'b0;
            OUT_DATA    <= '0;
            OUT_ZERO    <= 1'b0;
            OUT_DST     <= '0;
        end else begin
            head  <= head_next;
            count <= count_next;
            if (push) begin
                tail <= tail + PTR_W'(1);
                if (IN_ZERO != (IN_DATA == '0))
                    ZERO_ERR <= 1'b1;
            end
            if (discard && (DISCARD_CNT != 8'hFF))
                DISCARD_CNT <= DISCARD_CNT + 8'd1;

            // Registered show-ahead head; holds its last value once the queue drains.
            if (count_next != '0) begin
                if (bypass) begin
                    OUT_DATA <= IN_DATA;
                    OUT_ZERO <= IN_ZERO;
                    OUT_DST  <= IN_DST;
                end else begin
                    OUT_DATA <= mem_data[head_next];
                    OUT_ZERO <= mem_zero[head_next];
                    OUT_DST  <= mem_dst[head_next];
                end
            end
        end
    end
endmodule
